// File: rtl/color_fx_pkg.sv
// Shared types and constants for the colour-effects sequencer.
package color_fx_pkg;

  localparam int unsigned HUE_W = 6;
  localparam int unsigned LUM_W = 5;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_FLASH, S_OVER} fx_state_t;

  localparam logic [2:0] GS_START = 3'd0;
  localparam logic [2:0] GS_OVER  = 3'd4;

  localparam logic [HUE_W-1:0] LEVEL_HUE_JUMP = 6'd16;

  // Decay by one per frame, floor at zero.
  function automatic logic [LUM_W-1:0] sat_dec(input logic [LUM_W-1:0] v);
    return (v == '0) ? '0 : v - LUM_W'(1);
  endfunction

endpackage

// File: rtl/color_fx_sequencer_prescaler.sv
// Frame-rate prescaler: 4-bit counter advanced by frame ticks, with
// terminal-count pulse, synchronous clear and a bypass that fires every tick.
module frame_prescaler
  import color_fx_pkg::*;
#(
  parameter logic [CNT_W-1:0] TERMINAL = 4'd3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic en,
  input  logic clr,
  input  logic bypass,
  output logic tc_c
);

  logic [CNT_W-1:0] cnt;

  assign tc_c = tick & en & (bypass | (cnt == TERMINAL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      if (clr)
        cnt <= '0;
      else if (en && !bypass)
        cnt <= (cnt == TERMINAL) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/color_fx_sequencer.sv
// Frame-synchronous sequencer for the colour mapper's hue/luminance/saturation
// modifiers. Optional saturation pulse enabled by COLOR_FX_SAT_PULSE_EN.
module color_fx_sequencer
  import color_fx_pkg::*;
#(
  parameter int unsigned HUE_STEP_FRAMES = 4,
  parameter int unsigned FLASH_FRAMES    = 8,
  parameter int unsigned LUM_PULSE_PEAK  = 3
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_start,
  input  logic [2:0]  State,
  input  logic        beat,
  input  logic        level_up,
  input  logic        hit,
  output logic [5:0]  Hue_offset,
  output logic [4:0]  Luminance_offset,
  output logic [4:0]  Saturation_offset,
  output logic        invert_colors
);

  localparam logic [LUM_W-1:0] LUM_PEAK   = LUM_W'(LUM_PULSE_PEAK);
  localparam logic [CNT_W-1:0] FLASH_INIT = CNT_W'(FLASH_FRAMES - 1);
  localparam logic [CNT_W-1:0] HUE_TERM   = CNT_W'(HUE_STEP_FRAMES - 1);

  fx_state_t        fx_state;
  logic [CNT_W-1:0] flash_cnt;
  logic             pend_beat, pend_lvl, pend_hit;
  logic             beat_ev, lvl_ev, hit_ev;
  logic             gs_start, gs_over, gs_play;
  logic             pre_en, pre_clr, pre_bypass, hue_tick;

  // Sticky event capture; a pulse coincident with frame_start counts for that frame.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pend_beat <= 1'b0;
      pend_lvl  <= 1'b0;
      pend_hit  <= 1'b0;
    end else if (frame_start) begin
      pend_beat <= 1'b0;
      pend_lvl  <= 1'b0;
      pend_hit  <= 1'b0;
    end else begin
      if (beat)     pend_beat <= 1'b1;
      if (level_up) pend_lvl  <= 1'b1;
      if (hit)      pend_hit  <= 1'b1;
    end
  end

  assign beat_ev  = pend_beat | beat;
  assign lvl_ev   = pend_lvl | level_up;
  assign hit_ev   = pend_hit | hit;

  // Unused codes 5..7 behave like the start screen.
  assign gs_start = (State == GS_START) || (State > GS_OVER);
  assign gs_over  = (State == GS_OVER);
  assign gs_play  = !gs_start && !gs_over;

  assign pre_en     = (fx_state == S_IDLE) ||
                      ((fx_state == S_PLAY) && !gs_start && !hit_ev) ||
                      ((fx_state == S_OVER) && !gs_start);
  assign pre_clr    = ((fx_state == S_PLAY) && !gs_start && !hit_ev && lvl_ev) ||
                      ((fx_state == S_OVER) && gs_play);
  assign pre_bypass = (fx_state == S_OVER);

  frame_prescaler #(.TERMINAL(HUE_TERM)) u_hue_prescaler (
    .clk    (Clk),
    .rst_n  (Reset_n),
    .tick   (frame_start),
    .en     (pre_en),
    .clr    (pre_clr),
    .bypass (pre_bypass),
    .tc_c   (hue_tick)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fx_state         <= S_IDLE;
      flash_cnt        <= '0;
      Hue_offset       <= '0;
      Luminance_offset <= '0;
      invert_colors    <= 1'b0;
    end else if (frame_start) begin
      if (gs_start && (fx_state != S_IDLE)) begin
        // Return to the start screen aborts everything except the hue.
        fx_state         <= S_IDLE;
        flash_cnt        <= '0;
        Luminance_offset <= '0;
        invert_colors    <= 1'b0;
      end else begin
        case (fx_state)
          S_IDLE: begin
            if (hue_tick) Hue_offset <= Hue_offset + HUE_W'(1);
            Luminance_offset <= '0;
            invert_colors    <= 1'b0;
            if (gs_play) fx_state <= S_PLAY;
          end
          S_PLAY: begin
            if (hit_ev) begin
              fx_state         <= S_FLASH;
              flash_cnt        <= FLASH_INIT;
              invert_colors    <= 1'b1;
              Luminance_offset <= '0;
            end else begin
              if (lvl_ev)        Hue_offset <= Hue_offset + LEVEL_HUE_JUMP;
              else if (hue_tick) Hue_offset <= Hue_offset + HUE_W'(1);
              Luminance_offset <= beat_ev ? LUM_PEAK : sat_dec(Luminance_offset);
              if (gs_over) begin
                fx_state         <= S_OVER;
                Luminance_offset <= '0;
              end
            end
          end
          S_FLASH: begin
            if (flash_cnt == '0) begin
              invert_colors <= 1'b0;
              fx_state      <= gs_over ? S_OVER : S_PLAY;
            end else begin
              flash_cnt <= flash_cnt - CNT_W'(1);
            end
          end
          S_OVER: begin
            if (hue_tick) Hue_offset <= Hue_offset + HUE_W'(1);
            Luminance_offset <= '0;
            invert_colors    <= 1'b0;
            if (gs_play) fx_state <= S_PLAY;
          end
          default: fx_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef COLOR_FX_SAT_PULSE_EN
  logic sat_active;
  assign sat_active = (fx_state == S_PLAY) && gs_play && !hit_ev;

  // Saturation pulse tracks the luminance pulse, only while playing.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      Saturation_offset <= '0;
    else if (frame_start)
      Saturation_offset <= sat_active ? (beat_ev ? LUM_PEAK : sat_dec(Saturation_offset)) : '0;
  end
`else
  assign Saturation_offset = '0;
`endif

endmodule

// File: tb/tb_color_fx_sequencer.sv
// Directed self-checking bench for color_fx_sequencer (default parameters).
module tb_color_fx_sequencer;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_start = 1'b0;
  logic [2:0] State = 3'd0;
  logic       beat = 1'b0;
  logic       level_up = 1'b0;
  logic       hit = 1'b0;
  logic [5:0] Hue_offset;
  logic [4:0] Luminance_offset;
  logic [4:0] Saturation_offset;
  logic       invert_colors;

  int errors = 0;
  int checks = 0;

`ifdef COLOR_FX_SAT_PULSE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  color_fx_sequencer dut (
    .Clk               (Clk),
    .Reset_n           (Reset_n),
    .frame_start       (frame_start),
    .State             (State),
    .beat              (beat),
    .level_up          (level_up),
    .hit               (hit),
    .Hue_offset        (Hue_offset),
    .Luminance_offset  (Luminance_offset),
    .Saturation_offset (Saturation_offset),
    .invert_colors     (invert_colors)
  );

  always #5 Clk = ~Clk;

  task automatic do_frame(input logic [2:0] st, input logic b, input logic l, input logic h);
    @(negedge Clk);
    State = st; beat = b; level_up = l; hit = h; frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0; beat = 1'b0; level_up = 1'b0; hit = 1'b0;
    @(negedge Clk);
  endtask

  task automatic pulse(input logic b, input logic l, input logic h);
    @(negedge Clk);
    beat = b; level_up = l; hit = h;
    @(negedge Clk);
    beat = 1'b0; level_up = 1'b0; hit = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge Clk);
    Reset_n = 1'b0; State = 3'd0;
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    checks++;
    if (Hue_offset !== 6'd0) begin errors++; $display("FAIL reset_hue: got %0d expected 0", Hue_offset); end
    checks++;
    if (Luminance_offset !== 5'd0) begin errors++; $display("FAIL reset_lum: got %0d expected 0", Luminance_offset); end
    checks++;
    if (Saturation_offset !== 5'd0) begin errors++; $display("FAIL reset_sat: got %0d expected 0", Saturation_offset); end
    checks++;
    if (invert_colors !== 1'b0) begin errors++; $display("FAIL reset_inv: got %b expected 0", invert_colors); end
    Reset_n = 1'b1;
  endtask

  task automatic test_idle_hue;
    repeat (4) do_frame(3'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Hue_offset !== 6'd1) begin errors++; $display("FAIL idle_hue4: got %0d expected 1", Hue_offset); end
    repeat (4) do_frame(3'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Hue_offset !== 6'd2) begin errors++; $display("FAIL idle_hue8: got %0d expected 2", Hue_offset); end
    checks++;
    if (Luminance_offset !== 5'd0) begin errors++; $display("FAIL idle_lum: got %0d expected 0", Luminance_offset); end
    checks++;
    if (invert_colors !== 1'b0) begin errors++; $display("FAIL idle_inv: got %b expected 0", invert_colors); end
  endtask

  // Build hue up to 60 through the game-over spin, then wrap it with a level jump.
  task automatic test_level_wrap;
    do_reset();
    do_frame(3'd1, 1'b0, 1'b0, 1'b0);
    do_frame(3'd4, 1'b0, 1'b0, 1'b0);
    repeat (59) do_frame(3'd4, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Hue_offset !== 6'd59) begin errors++; $display("FAIL over_spin: got %0d expected 59", Hue_offset); end
    do_frame(3'd1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Hue_offset !== 6'd60) begin errors++; $display("FAIL over_exit_hue: got %0d expected 60", Hue_offset); end
    do_frame(3'd1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (Hue_offset !== 6'd12) begin errors++; $display("FAIL level_wrap: got %0d expected 12", Hue_offset); end
    repeat (3) do_frame(3'd1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Hue_offset !== 6'd12) begin errors++; $display("FAIL prescale_restart3: got %0d expected 12", Hue_offset); end
    do_frame(3'd1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Hue_offset !== 6'd13) begin errors++; $display("FAIL prescale_restart4: got %0d expected 13", Hue_offset); end
  endtask

  task automatic test_beat;
    logic [4:0] exp_lum [7];
    logic [4:0] exp_sat;
    exp_lum = '{5'd3, 5'd2, 5'd1, 5'd0, 5'd0, 5'd3, 5'd2};
    for (int i = 0; i < 7; i++) begin
      do_frame(3'd1, (i == 0) || (i == 5), 1'b0, 1'b0);
      exp_sat = SAT_EN ? exp_lum[i] : 5'd0;
      checks++;
      if (Luminance_offset !== exp_lum[i]) begin
        errors++; $display("FAIL beat_lum[%0d]: got %0d expected %0d", i, Luminance_offset, exp_lum[i]);
      end
      checks++;
      if (Saturation_offset !== exp_sat) begin
        errors++; $display("FAIL beat_sat[%0d]: got %0d expected %0d", i, Saturation_offset, exp_sat);
      end
    end
    // Beat arriving between frames is held until the next frame_start.
    pulse(1'b1, 1'b0, 1'b0);
    do_frame(3'd1, 1'b0, 1'b0, 1'b0);
    exp_sat = SAT_EN ? 5'd3 : 5'd0;
    checks++;
    if (Luminance_offset !== 5'd3) begin errors++; $display("FAIL beat_reload: got %0d expected 3", Luminance_offset); end
    checks++;
    if (Saturation_offset !== exp_sat) begin errors++; $display("FAIL sat_reload: got %0d expected %0d", Saturation_offset, exp_sat); end
    checks++;
    if (Hue_offset !== 6'd15) begin errors++; $display("FAIL beat_hue: got %0d expected 15", Hue_offset); end
  endtask

  task automatic test_hit;
    do_frame(3'd1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (invert_colors !== 1'b1) begin errors++; $display("FAIL hit_inv: got %b expected 1", invert_colors); end
    checks++;
    if (Luminance_offset !== 5'd0) begin errors++; $display("FAIL hit_lum: got %0d expected 0", Luminance_offset); end
    checks++;
    if (Saturation_offset !== 5'd0) begin errors++; $display("FAIL hit_sat: got %0d expected 0", Saturation_offset); end
    for (int i = 1; i <= 7; i++) begin
      do_frame((i == 7) ? 3'd4 : 3'd1, i == 5, i == 5, i == 3);
      checks++;
      if (invert_colors !== 1'b1) begin errors++; $display("FAIL flash_inv[%0d]: got %b expected 1", i, invert_colors); end
      checks++;
      if (Hue_offset !== 6'd15) begin errors++; $display("FAIL flash_hue[%0d]: got %0d expected 15", i, Hue_offset); end
      checks++;
      if (Luminance_offset !== 5'd0) begin errors++; $display("FAIL flash_lum[%0d]: got %0d expected 0", i, Luminance_offset); end
    end
    do_frame(3'd4, 1'b0, 1'b0, 1'b0);
    checks++;
    if (invert_colors !== 1'b0) begin errors++; $display("FAIL flash_end_inv: got %b expected 0", invert_colors); end
    checks++;
    if (Hue_offset !== 6'd15) begin errors++; $display("FAIL flash_end_hue: got %0d expected 15", Hue_offset); end
    do_frame(3'd4, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Hue_offset !== 6'd16) begin errors++; $display("FAIL over_hue1: got %0d expected 16", Hue_offset); end
    do_frame(3'd4, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Hue_offset !== 6'd17) begin errors++; $display("FAIL over_hue2: got %0d expected 17", Hue_offset); end
  endtask

  task automatic test_abort;
    do_reset();
    do_frame(3'd1, 1'b0, 1'b0, 1'b0);
    do_frame(3'd1, 1'b0, 1'b0, 1'b1);
    do_frame(3'd1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (invert_colors !== 1'b1) begin errors++; $display("FAIL abort_pre_inv: got %b expected 1", invert_colors); end
    do_frame(3'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (invert_colors !== 1'b0) begin errors++; $display("FAIL abort_inv: got %b expected 0", invert_colors); end
    checks++;
    if (Hue_offset !== 6'd0) begin errors++; $display("FAIL abort_hue: got %0d expected 0", Hue_offset); end
    // Back in IDLE the prescaler resumes from its held count of 1.
    repeat (2) do_frame(3'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Hue_offset !== 6'd0) begin errors++; $display("FAIL abort_idle2: got %0d expected 0", Hue_offset); end
    do_frame(3'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Hue_offset !== 6'd1) begin errors++; $display("FAIL abort_idle3: got %0d expected 1", Hue_offset); end
    // Asynchronous reset in the middle of a flash.
    do_frame(3'd1, 1'b0, 1'b0, 1'b0);
    do_frame(3'd1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (invert_colors !== 1'b1) begin errors++; $display("FAIL rst_pre_inv: got %b expected 1", invert_colors); end
    @(negedge Clk);
    #1 Reset_n = 1'b0;
    #1;
    checks++;
    if (invert_colors !== 1'b0) begin errors++; $display("FAIL async_rst_inv: got %b expected 0", invert_colors); end
    checks++;
    if (Hue_offset !== 6'd0) begin errors++; $display("FAIL async_rst_hue: got %0d expected 0", Hue_offset); end
    checks++;
    if (Luminance_offset !== 5'd0) begin errors++; $display("FAIL async_rst_lum: got %0d expected 0", Luminance_offset); end
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_flag_clear;
    do_reset();
    pulse(1'b1, 1'b1, 1'b0);
    do_frame(3'd1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Luminance_offset !== 5'd0) begin errors++; $display("FAIL idle_beat_ignored: got %0d expected 0", Luminance_offset); end
    do_frame(3'd1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (Luminance_offset !== 5'd0) begin errors++; $display("FAIL stale_beat: got %0d expected 0", Luminance_offset); end
    checks++;
    if (Hue_offset !== 6'd0) begin errors++; $display("FAIL stale_level: got %0d expected 0", Hue_offset); end
  endtask

  initial begin
    test_reset();
    test_idle_hue();
    test_level_wrap();
    test_beat();
    test_hit();
    test_abort();
    test_flag_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
